// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage definitions: ALU function codes and the machine word type.
package y86_pkg;

  localparam int unsigned WORD_W = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_fn_e;

endpackage

// File: rtl/y86_addsub.sv
// Combinational WIDTH-bit adder/subtractor with signed-overflow detection.
// Subtraction is a + ~b + 1: b is inverted and i_sub doubles as the carry-in.
module y86_addsub #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;

  // Operand conditioning, sum and overflow; the carry-out is deliberately dropped.
  always_comb begin
    w_b_eff = i_sub ? ~i_b : i_b;
    w_sum   = i_a + w_b_eff + {{(WIDTH-1){1'b0}}, i_sub};
    // Overflow when both effective operands share a sign the result does not.
    o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    o_sum   = w_sum;
  end

endmodule

// File: rtl/y86_alu64.sv
// Y86-64 execute-stage ALU: ADD/SUB/AND/XOR with a registered result and signed-overflow flag.
// One operation per cycle, result one cycle after the operands are sampled.
// Optional feature macro ALU_CC_EN adds the registered condition-code port o_cc = {zf,sf,of}.
module y86_alu64
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_control,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_ans,
`ifdef ALU_CC_EN
  output logic [2:0]       o_cc,
`endif
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_ans;
  logic             w_ovf;

  logic [WIDTH-1:0] r_ans;
  logic             r_ovf;

  assign w_is_sub = (i_control == ALU_SUB);

  y86_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a   (i_a),
    .i_b   (i_b),
    .i_sub (w_is_sub),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // Result select; logical ops never flag overflow.
  always_comb begin
    w_ans = '0;
    w_ovf = 1'b0;
    unique case (alu_fn_e'(i_control))
      ALU_ADD, ALU_SUB: begin
        w_ans = w_sum;
        w_ovf = w_add_ovf;
      end
      ALU_AND: w_ans = i_a & i_b;
      ALU_XOR: w_ans = i_a ^ i_b;
    endcase
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ans <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ans <= w_ans;
      r_ovf <= w_ovf;
    end
  end

  assign o_ans      = r_ans;
  assign o_overflow = r_ovf;

`ifdef ALU_CC_EN
  logic [2:0] r_cc;

  // Condition codes from the next result, captured on the same edge as the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= 3'b000;
    end else begin
      r_cc <= {(w_ans == '0), w_ans[WIDTH-1], w_ovf};
    end
  end

  assign o_cc = r_cc;
`endif

endmodule

// File: tb/tb_y86_alu64.sv
// Scoreboard bench for y86_alu64: directed and random operations, expected results queued at issue
// and compared by a monitor one clock later. Define ALU_CC_EN to also check o_cc.
module tb_y86_alu64;
  import y86_pkg::*;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   i_control;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic [W-1:0] o_ans;
  logic         o_overflow;
`ifdef ALU_CC_EN
  logic [2:0]   o_cc;
`endif

  always #5 clk = ~clk;

  y86_alu64 #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_control  (i_control),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_ans      (o_ans),
`ifdef ALU_CC_EN
    .o_cc       (o_cc),
`endif
    .o_overflow (o_overflow)
  );

  typedef struct packed {
    logic [W-1:0] ans;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [1:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ans;
    logic         ovf;
  } dir_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: exact signed arithmetic one bit wider; overflow means the true value does not
  // fit in W-bit two's complement.
  function automatic exp_t ref_model(input logic [1:0] fn, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    logic signed [W:0] wide;
    exp_t e;
    e.ovf = 1'b0;
    case (fn)
      2'd0: begin
        wide  = $signed({a[W-1], a}) + $signed({b[W-1], b});
        e.ans = wide[W-1:0];
        e.ovf = (wide[W] != wide[W-1]);
      end
      2'd1: begin
        wide  = $signed({a[W-1], a}) - $signed({b[W-1], b});
        e.ans = wide[W-1:0];
        e.ovf = (wide[W] != wide[W-1]);
      end
      2'd2:    e.ans = a & b;
      default: e.ans = a ^ b;
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return {1'b0, {(W-1){1'b1}}};
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return '0;
      3:       return '1;
      4:       return W'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Drive one operation (caller is at a negedge) and queue its expected response.
  task automatic issue(input logic [1:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e);
    i_control = fn;
    i_a       = a;
    i_b       = b;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a result every cycle; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ans", o_ans, e.ans);
        check("overflow", W'(o_overflow), W'(e.ovf));
`ifdef ALU_CC_EN
        check("cc", W'(o_cc), W'({(e.ans == '0), e.ans[W-1], e.ovf}));
`endif
      end
    end
  end

  task automatic check_zero(input string name);
    check({name, "_ans"}, o_ans, '0);
    check({name, "_ovf"}, W'(o_overflow), '0);
`ifdef ALU_CC_EN
    check({name, "_cc"}, W'(o_cc), '0);
`endif
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  localparam logic [W-1:0] MaxW = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinW = {1'b1, {(W-1){1'b0}}};

  dir_t dirs[16];

  initial begin
    dirs = '{
      '{2'b00, 64'd11,  64'd4,  64'd15,  1'b0},
      '{2'b01, 64'd11,  64'd4,  64'd7,   1'b0},
      '{2'b10, 64'd11,  64'd4,  64'd0,   1'b0},
      '{2'b11, 64'd11,  64'd4,  64'd15,  1'b0},
      '{2'b00, -64'sd11, 64'd4, -64'sd7,  1'b0},
      '{2'b01, -64'sd11, 64'd4, -64'sd15, 1'b0},
      '{2'b10, -64'sd11, 64'd4, 64'd4,    1'b0},
      '{2'b11, -64'sd11, 64'd4, -64'sd15, 1'b0},
      '{2'b00, -64'sd11, -64'sd4, -64'sd15, 1'b0},
      '{2'b01, -64'sd11, -64'sd4, -64'sd7,  1'b0},
      '{2'b00, MaxW, 64'd1, MinW, 1'b1},
      '{2'b01, MinW, 64'd1, MaxW, 1'b1},
      '{2'b00, 64'd2147483647, 64'd1, 64'd2147483648, 1'b0},
      '{2'b01, 64'd5,  64'd5,  64'd0,   1'b0},
      '{2'b00, MinW, MinW, 64'd0, 1'b1},
      '{2'b00, 64'd11, 64'd4, 64'd15, 1'b0}
    };

    // Reset with nonzero inputs; outputs must stay cleared across clock edges.
    rst_n     = 1'b0;
    i_control = 2'b00;
    i_a       = 64'd11;
    i_b       = 64'd4;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // Release at a negedge: still zero until the next rising edge captures.
    @(negedge clk);
    rst_n = 1'b1;
    issue(dirs[0].fn, dirs[0].a, dirs[0].b, '{dirs[0].ans, dirs[0].ovf});
    #1;
    check_zero("post_release");

    // Directed, back-to-back.
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      issue(dirs[i].fn, dirs[i].a, dirs[i].b, '{dirs[i].ans, dirs[i].ovf});
    end

    // Random stream against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0]   fn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      fn = 2'($urandom_range(0, 3));
      a  = rand_word();
      b  = rand_word();
      @(negedge clk);
      issue(fn, a, b, ref_model(fn, a, b));
    end

    // Finish with a known nonzero result so the asynchronous clear is visible.
    @(negedge clk);
    issue(2'b00, 64'd11, 64'd4, ref_model(2'b00, 64'd11, 64'd4));
    drain();
    check("pre_async_ans", o_ans, 64'd15);

    // Asynchronous reset away from any edge.
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("async_hold");

    // Mid-stream restart: first capture on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b01, MinW, 64'd1, ref_model(2'b01, MinW, 64'd1));
    for (int i = 0; i < 20; i++) begin
      logic [1:0]   fn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      fn = 2'($urandom_range(0, 3));
      a  = rand_word();
      b  = rand_word();
      @(negedge clk);
      issue(fn, a, b, ref_model(fn, a, b));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
